// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared FSM encoding and stream constants for the image loader
package imem_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;
  localparam int HDR_BYTES = 2;
  localparam int MEM_BYTES_DEF = 1269;
endpackage

// File: rtl/imem_loader_csum.sv
// imem_loader_csum: running XOR of image bytes, cleared at session start
module imem_loader_csum (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_acc
);
  logic [7:0] r_acc;
  // fold each accepted data byte into the accumulator
  always_ff @(posedge clk or posedge rst)
    if (rst) r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en) r_acc <= r_acc ^ i_data;
  assign o_acc = r_acc;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed, XOR-checksummed image into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          MEM_BYTES = MEM_BYTES_DEF,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [10:0] byte_cnt
);
  state_t      r_state, w_next;
  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic        r_we;
  logic [31:0] r_addr;
  logic [7:0]  r_wdata;
  logic [10:0] r_cnt;
  logic        w_acc, w_start, w_data_acc, w_last;
  logic [15:0] w_len_in;
  logic [7:0]  w_sum;
  assign rx_ready   = r_state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
  assign w_acc      = rx_valid & rx_ready;
  assign w_start    = start & (r_state inside {S_IDLE, S_DONE, S_ERR});
  assign w_data_acc = w_acc & (r_state == S_DATA);
  assign w_len_in   = {rx_data, r_len_lo};
  assign w_last     = (16'(r_cnt) + 16'd1) == r_len;
  imem_loader_csum u_csum (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_en   (w_data_acc),
    .i_data (rx_data),
    .o_acc  (w_sum)
  );
  // state register; reset aborts any session immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // next state: header, payload, checksum; terminal states wait for a new start
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: w_next = start ? S_LEN_LO : r_state;
      S_LEN_LO: w_next = w_acc ? S_LEN_HI : r_state;
      S_LEN_HI: w_next = !w_acc ? r_state :
                         (w_len_in > 16'(MEM_BYTES)) ? S_ERR :
                         (w_len_in == 16'd0) ? S_CSUM : S_DATA;
      S_DATA:   w_next = (w_acc && w_last) ? S_CSUM : r_state;
      S_CSUM:   w_next = !w_acc ? r_state : (rx_data == w_sum) ? S_DONE : S_ERR;
      default:  w_next = S_IDLE;
    endcase
  end
  // write port registered one cycle after acceptance; byte count doubles as write offset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_len_lo <= '0;
      r_len    <= '0;
    end else begin
      r_we <= w_data_acc;
      if (w_data_acc) begin
        r_addr  <= BASE_ADDR + 32'(r_cnt);
        r_wdata <= rx_data;
      end
      if (w_start) r_cnt <= '0;
      else if (w_data_acc) r_cnt <= r_cnt + 11'd1;
      if (w_acc && r_state == S_LEN_LO) r_len_lo <= rx_data;
      if (w_acc && r_state == S_LEN_HI) r_len <= w_len_in;
    end
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign byte_cnt  = r_cnt;
  assign done      = r_state == S_DONE;
  assign err       = r_state == S_ERR;
  assign cpu_hold  = !(r_state inside {S_IDLE, S_DONE});
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vector table plus multi-cycle corner sequences for imem_loader
module tb_imem_loader;
  import imem_loader_pkg::*;
  logic        clk, rst, start, rx_valid, rx_ready, mem_we, cpu_hold, done, err;
  logic [7:0]  rx_data, mem_wdata;
  logic [31:0] mem_addr;
  logic [10:0] byte_cnt;
  int n_vec, n_bad, wcount;
  logic [7:0] mem [0:2047];
  typedef struct {
    logic        s, va;
    logic [7:0]  d;
    logic        r, w;
    logic [31:0] a;
    logic [7:0]  wd;
    logic        h, dn, e;
    logic [10:0] c;
  } vec_t;
  vec_t tbl[$];
  imem_loader #(.MEM_BYTES(MEM_BYTES_DEF), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .byte_cnt(byte_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk)
    if (mem_we) begin
      mem[mem_addr[10:0]] <= mem_wdata;
      wcount <= wcount + 1;
    end
  function automatic vec_t v(input logic s, va, input logic [7:0] d, input logic r, w,
                             input logic [31:0] a, input logic [7:0] wd,
                             input logic h, dn, e, input logic [10:0] c);
    vec_t x;
    x.s = s; x.va = va; x.d = d; x.r = r; x.w = w; x.a = a; x.wd = wd;
    x.h = h; x.dn = dn; x.e = e; x.c = c;
    return x;
  endfunction
  function automatic logic [55:0] pk(input logic r, w, input logic [31:0] a,
                                     input logic [7:0] wd, input logic h, dn, e,
                                     input logic [10:0] c);
    return {r, w, a, wd, h, dn, e, c};
  endfunction
  function automatic logic [55:0] outs();
    return pk(rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err, byte_cnt);
  endfunction
  task automatic chk(input string name, input logic [55:0] got, input logic [55:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      start = tbl[i].s; rx_valid = tbl[i].va; rx_data = tbl[i].d;
      @(posedge clk); #1;
      chk($sformatf("row%0d", i), outs(),
          pk(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].h, tbl[i].dn, tbl[i].e, tbl[i].c));
    end
    start = 1'b0; rx_valid = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] d);
    int t;
    t = 0;
    rx_valid = 1'b1; rx_data = d;
    while (!rx_ready && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk("ready_wait", {55'd0, rx_ready}, 56'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask
  initial begin
    logic [7:0] img [7];
    int w0;
    n_vec = 0; n_bad = 0; wcount = 0;
    start = 0; rx_valid = 0; rx_data = 0; rst = 1'b1;
    #3;
    chk("reset", outs(), 56'd0);
    @(negedge clk); rst = 1'b0;
    // basic load 04 00 13 05 A0 00 B6
    tbl.push_back(v(1,0,8'h00, 1,0,32'd0,8'h00, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'h04, 1,0,32'd0,8'h00, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'h00, 1,0,32'd0,8'h00, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'h13, 1,1,32'd0,8'h13, 1,0,0,11'd1));
    tbl.push_back(v(0,1,8'h05, 1,1,32'd1,8'h05, 1,0,0,11'd2));
    tbl.push_back(v(0,1,8'hA0, 1,1,32'd2,8'hA0, 1,0,0,11'd3));
    tbl.push_back(v(0,1,8'h00, 1,1,32'd3,8'h00, 1,0,0,11'd4));
    tbl.push_back(v(0,1,8'hB6, 0,0,32'd3,8'h00, 0,1,0,11'd4));
    tbl.push_back(v(0,0,8'h00, 0,0,32'd3,8'h00, 0,1,0,11'd4));
    // empty image, then restart from DONE
    tbl.push_back(v(1,0,8'h00, 1,0,32'd3,8'h00, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'h00, 1,0,32'd3,8'h00, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'h00, 1,0,32'd3,8'h00, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'h00, 0,0,32'd3,8'h00, 0,1,0,11'd0));
    tbl.push_back(v(1,0,8'h00, 1,0,32'd3,8'h00, 1,0,0,11'd0));
    // bad checksum 02 00 AA 55 00, then a byte offered in ERR is ignored
    tbl.push_back(v(0,1,8'h02, 1,0,32'd3,8'h00, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'h00, 1,0,32'd3,8'h00, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'hAA, 1,1,32'd0,8'hAA, 1,0,0,11'd1));
    tbl.push_back(v(0,1,8'h55, 1,1,32'd1,8'h55, 1,0,0,11'd2));
    tbl.push_back(v(0,1,8'h00, 0,0,32'd1,8'h55, 1,0,1,11'd2));
    tbl.push_back(v(0,1,8'h12, 0,0,32'd1,8'h55, 1,0,1,11'd2));
    // oversize length 1270
    tbl.push_back(v(1,0,8'h00, 1,0,32'd1,8'h55, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'hF6, 1,0,32'd1,8'h55, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'h04, 0,0,32'd1,8'h55, 1,0,1,11'd0));
    // exactly MEM_BYTES (1269) is accepted; start ignored mid-session
    tbl.push_back(v(1,0,8'h00, 1,0,32'd1,8'h55, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'hF5, 1,0,32'd1,8'h55, 1,0,0,11'd0));
    tbl.push_back(v(0,1,8'h04, 1,0,32'd1,8'h55, 1,0,0,11'd0));
    tbl.push_back(v(1,0,8'h00, 1,0,32'd1,8'h55, 1,0,0,11'd0));
    tbl.push_back(v(1,1,8'h33, 1,1,32'd0,8'h33, 1,0,0,11'd1));
    w0 = wcount;
    run_rows(0, 8);
    chk("basic_writes", 56'(wcount - w0), 56'd4);
    chk("basic_fetch", 56'({mem[3], mem[2], mem[1], mem[0]}), 56'h00A00513);
    w0 = wcount;
    run_rows(9, 19);
    chk("badsum_writes", 56'(wcount - w0), 56'd2);
    w0 = wcount;
    run_rows(20, 22);
    chk("oversize_writes", 56'(wcount - w0), 56'd0);
    run_rows(23, 27);
    // backpressure: 3 idle cycles between every byte
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    img = '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
    for (int i = 0; i < 4; i++) mem[i] = 8'hFF;
    @(posedge clk); #1;
    w0 = wcount;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      repeat (3) @(posedge clk);
      #1;
      send_byte(img[i]);
    end
    @(posedge clk); #1;
    chk("bp_writes", 56'(wcount - w0), 56'(7 - HDR_BYTES - 1));
    chk("bp_fetch", 56'({mem[3], mem[2], mem[1], mem[0]}), 56'h00A00513);
    chk("bp_final", outs(), pk(0, 0, 32'd3, 8'h00, 0, 1, 0, 11'd4));
    // reset mid-DATA after 2 of 4 data bytes
    pulse_start();
    send_byte(8'h04); send_byte(8'h00); send_byte(8'h13); send_byte(8'h05);
    chk("pre_reset", outs(), pk(1, 1, 32'd1, 8'h05, 1, 0, 0, 11'd2));
    rst = 1'b1; #1;
    chk("async_reset", outs(), 56'd0);
    @(negedge clk); rst = 1'b0;
    w0 = wcount;
    rx_valid = 1'b1; rx_data = 8'hA0;
    repeat (5) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("post_reset_outs", outs(), 56'd0);
    chk("post_reset_writes", 56'(wcount - w0), 56'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
